// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shifter: LSL/LSR/ASR (and optional ROR) applied MAX_STEP bits per cycle.
// Optional feature: define SHIFT_SEQ8_ROR_EN to make op=11 a rotate-right; otherwise op=11 is LSL.
module shift_seq8 #(
  parameter int unsigned MAX_STEP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] d_in,
  input  logic [2:0] amt,
  output logic       busy,
  output logic       done,
  output logic [7:0] d_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [2:0] STEP_MAX = 3'(MAX_STEP);

  state_t     state, state_nx;
  logic [2:0] rem, rem_nx;
  logic [1:0] op_q, op_nx;
  logic [7:0] d_nx;
  logic [2:0] step;
  logic [7:0] shifted;
  logic [7:0] asr_res;

  // step never exceeds rem, so rem - step cannot wrap
  assign step    = (rem > STEP_MAX) ? STEP_MAX : rem;
  assign asr_res = $signed(d_out) >>> step;

  always_comb begin
    shifted = d_out << step;
    case (op_q)
      2'b01:   shifted = d_out >> step;
      2'b10:   shifted = asr_res;
`ifdef SHIFT_SEQ8_ROR_EN
      2'b11:   shifted = 8'({d_out, d_out} >> step);
`endif
      default: shifted = d_out << step;
    endcase
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    op_nx    = op_q;
    d_nx     = d_out;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          d_nx     = d_in;
          rem_nx   = amt;
          op_nx    = op;
          state_nx = (amt != 3'd0) ? SHIFT : DONE;
        end else if (state == DONE) begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        d_nx   = shifted;
        rem_nx = rem - step;
        if (rem <= STEP_MAX) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      op_q  <= '0;
      d_out <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      op_q  <= op_nx;
      d_out <= d_nx;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8 (MAX_STEP=3) using a queue of expected results.
module tb_shift_seq8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = '0;
  logic [7:0] d_in = '0;
  logic [2:0] amt = '0;
  logic       busy, done;
  logic [7:0] d_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         lat;
    int         busy_n;
  } exp_t;

  exp_t sb[$];

  shift_seq8 #(.MAX_STEP(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .d_in(d_in),
    .amt(amt), .busy(busy), .done(done), .d_out(d_out)
  );

  always #5 clk = ~clk;

  // Reference: apply the whole distance one bit at a time.
  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] d, input logic [2:0] a);
    logic [7:0] r;
    r = d;
    for (int unsigned i = 0; i < a; i++) begin
      case (o)
        2'b01: r = {1'b0, r[7:1]};
        2'b10: r = {d[7], r[7:1]};
`ifdef SHIFT_SEQ8_ROR_EN
        2'b11: r = {r[0], r[7:1]};
`endif
        default: r = {r[6:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  // Drive a request at a negedge; returns at the negedge of cycle 1 with start low.
  task automatic launch(input logic [1:0] o, input logic [7:0] d, input logic [2:0] a);
    exp_t e;
    e.data   = model(o, d, a);
    e.busy_n = (int'(a) + 2) / 3;
    e.lat    = 1 + e.busy_n;
    sb.push_back(e);
    start = 1'b1; op = o; d_in = d; amt = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b d_out=%h, required 0 0 00", busy, done, d_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ops;
    logic [1:0] ops [12];
    logic [7:0] ds  [12];
    logic [2:0] as  [12];
    exp_t e;
    int cyc, bn;
    ops = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11};
    ds  = '{8'h81, 8'h81, 8'h81, 8'h5A, 8'h81, 8'h3C, 8'h7F, 8'hFF, 8'hC3, 8'hA5, 8'h96, 8'h01};
    as  = '{3'd7,  3'd5,  3'd4,  3'd0,  3'd1,  3'd3,  3'd6,  3'd1,  3'd2,  3'd7,  3'd6,  3'd3};
    for (int k = 0; k < 16; k++) begin
      if (k < 12) launch(ops[k], ds[k], as[k]);
      else launch(2'($urandom_range(3)), 8'($urandom_range(255)), 3'($urandom_range(7)));
      cyc = 1; bn = 0;
      while (done !== 1'b1 && cyc < 20) begin
        if (busy === 1'b1) bn++;
        @(negedge clk);
        cyc++;
      end
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL op_timeout[%0d]: no done within %0d cycles", k, cyc);
      end else if (cyc != e.lat || bn != e.busy_n || d_out !== e.data) begin
        errors++;
        $display("FAIL op_result[%0d]: d_out=%h lat=%0d busy=%0d, required d_out=%h lat=%0d busy=%0d",
                 k, d_out, cyc, bn, e.data, e.lat, e.busy_n);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || d_out !== e.data) begin
        errors++;
        $display("FAIL done_one_cycle[%0d]: done=%b busy=%b d_out=%h, required 0 0 %h", k, done, busy, d_out, e.data);
      end
    end
  endtask

  task automatic test_ignore_while_busy;
    exp_t e;
    int cyc;
    launch(2'b00, 8'h81, 3'd7);
    start = 1'b1; op = 2'b01; d_in = 8'hFF; amt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || cyc != e.lat || d_out !== e.data) begin
      errors++;
      $display("FAIL ignore_busy: done=%b lat=%0d d_out=%h, required 1 %0d %h", done, cyc, d_out, e.lat, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    launch(2'b01, 8'hF0, 3'd2);
    start = 1'b1; op = 2'b10; d_in = 8'h80; amt = 3'd3;
    e.data = model(2'b10, 8'h80, 3'd3); e.busy_n = 1; e.lat = 2;
    sb.push_back(e);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_busy: busy=%b, required 1", busy);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || d_out !== e.data) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b d_out=%h, required 1 %h", done, d_out, e.data);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%b, required 1", busy);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || d_out !== e.data) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b d_out=%h, required 1 %h", done, d_out, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int seen;
    launch(2'b00, 8'hFF, 3'd7);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b d_out=%h, required 0 0 00", busy, done, d_out);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles after abort, required 0", seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ops();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
